argmax_frame_sequencer: RTL and testbench

- Collects the 10 signed output-layer scores of one inference, streamed one per handshake, into a packed 10-lane vector.
- Drives that vector into the external combinational 10-way signed maximum unit and waits a programmable settle time.
- Captures the winning digit index and value, then presents them to the display/result consumer with a valid/ready handshake.
- Sits between the final DNN layer and the digit display logic.

---
 rtl/argmax_frame_sequencer.sv | 135 +++++++++++++
 tb/tb_argmax_frame_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/argmax_frame_sequencer.sv
// argmax_frame_sequencer
// Gathers the ten output-layer scores of one inference into a packed lane
// vector, lets the external 10-way max unit settle, then captures the winning
// digit and hands it to the result consumer with a valid/ready handshake.
module argmax_frame_sequencer #(
    parameter int DATA_W        = 16,
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     frame_clr,
    input  logic signed [DATA_W-1:0] score_in,
    input  logic                     score_valid,
    output logic                     score_ready,
    output logic [10*DATA_W-1:0]     pack_out,
    input  logic signed [DATA_W-1:0] max_val_in,
    input  logic [3:0]               max_idx_in,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic [3:0]               result_idx,
    output logic signed [DATA_W-1:0] result_val,
    output logic                     idx_err,
    output logic                     busy,
    output logic [CNT_W-1:0]         frame_count
);

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SETTLE  = 2'd1,
        HOLD    = 2'd2
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    logic [3:0] lane_cnt_reg;
    logic [3:0] settle_cnt_reg;
    logic       score_fire;

    // A score is taken only when the source offers it and we are collecting.
    assign score_fire = score_valid && score_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= COLLECT;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic; an abort always returns to collecting a fresh frame.
    always_comb begin
        state_next = state_reg;
        if (frame_clr) begin
            state_next = COLLECT;
        end else begin
            case (state_reg)
                COLLECT: if (score_fire && lane_cnt_reg == 4'd9) state_next = SETTLE;
                SETTLE:  if (settle_cnt_reg == 4'd0) state_next = HOLD;
                HOLD:    if (result_valid && result_ready) state_next = COLLECT;
                default: state_next = COLLECT;
            endcase
        end
    end

    // Handshake/status outputs decoded from the registered state.
    always_comb begin
        score_ready = (state_reg == COLLECT) && !frame_clr;
        busy        = (state_reg != COLLECT);
    end

    // Counters, result capture and consumer handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_reg   <= 4'd0;
            settle_cnt_reg <= 4'd0;
            result_valid   <= 1'b0;
            result_idx     <= 4'd0;
            result_val     <= '0;
            idx_err        <= 1'b0;
            frame_count    <= '0;
        end else if (frame_clr) begin
            // Result fields, error flag and frame count deliberately hold.
            lane_cnt_reg   <= 4'd0;
            settle_cnt_reg <= 4'd0;
            result_valid   <= 1'b0;
        end else begin
            case (state_reg)
                COLLECT: begin
                    if (score_fire) begin
                        if (lane_cnt_reg == 4'd9) begin
                            lane_cnt_reg   <= 4'd0;
                            settle_cnt_reg <= 4'(SETTLE_CYCLES - 1);
                        end else begin
                            lane_cnt_reg <= lane_cnt_reg + 4'd1;
                        end
                    end
                end
                SETTLE: begin
                    if (settle_cnt_reg == 4'd0) begin
                        result_idx   <= max_idx_in;
                        result_val   <= max_val_in;
                        idx_err      <= (max_idx_in > 4'd9);
                        result_valid <= 1'b1;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg - 4'd1;
                    end
                end
                HOLD: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        frame_count  <= frame_count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Lane storage: digit k lands in lane 9-k, so digit 0 is the top lane.
    generate
        for (genvar gi = 0; gi < 10; gi++) begin : g_lane
            // Write this lane when the arriving digit maps onto it.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pack_out[DATA_W*gi +: DATA_W] <= '0;
                end else if (score_fire && lane_cnt_reg == 4'(9 - gi)) begin
                    pack_out[DATA_W*gi +: DATA_W] <= score_in;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_argmax_frame_sequencer.sv
// Bench for argmax_frame_sequencer: a behavioural max unit closes the loop,
// and expected winners are derived directly from the score list of each frame.
module tb_argmax_frame_sequencer;
    localparam int DW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_n4 = 1'b0;
    always #5 clk = ~clk;

    logic                 frame_clr = 1'b0;
    logic signed [DW-1:0] score_in = '0;
    logic                 score_valid = 1'b0;
    logic                 result_ready = 1'b0;

    logic                 score_ready, result_valid, idx_err, busy;
    logic [10*DW-1:0]     pack_out;
    logic signed [DW-1:0] max_val, result_val;
    logic [3:0]           max_idx, result_idx;
    logic [15:0]          frame_count;

    logic                 score_ready4, result_valid4, idx_err4, busy4;
    logic [10*DW-1:0]     pack_out4;
    logic signed [DW-1:0] max_val4, result_val4;
    logic [3:0]           max_idx4, result_idx4;
    logic [15:0]          frame_count4;

    logic       force_en = 1'b0;
    logic [3:0] force_idx = 4'd0;

    int total = 0;
    int bad = 0;
    int exp_fc = 0;
    logic signed [DW-1:0] fs [10];

    argmax_frame_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .frame_clr(frame_clr), .score_in(score_in),
        .score_valid(score_valid), .score_ready(score_ready), .pack_out(pack_out),
        .max_val_in(max_val), .max_idx_in(max_idx), .result_valid(result_valid),
        .result_ready(result_ready), .result_idx(result_idx), .result_val(result_val),
        .idx_err(idx_err), .busy(busy), .frame_count(frame_count));

    argmax_frame_sequencer #(.DATA_W(DW), .SETTLE_CYCLES(4), .CNT_W(16)) dut4 (
        .clk(clk), .rst_n(rst_n4), .frame_clr(frame_clr), .score_in(score_in),
        .score_valid(score_valid), .score_ready(score_ready4), .pack_out(pack_out4),
        .max_val_in(max_val4), .max_idx_in(max_idx4), .result_valid(result_valid4),
        .result_ready(result_ready), .result_idx(result_idx4), .result_val(result_val4),
        .idx_err(idx_err4), .busy(busy4), .frame_count(frame_count4));

    // Behavioural external max unit: lane L is digit 9-L, ties go to the lower digit.
    function automatic logic [DW+3:0] max_unit(input logic [10*DW-1:0] p);
        logic signed [DW-1:0] best, v;
        int bi;
        best = p[DW*9 +: DW];
        bi = 0;
        for (int d = 1; d < 10; d++) begin
            v = p[DW*(9-d) +: DW];
            if (v > best) begin best = v; bi = d; end
        end
        return {4'(bi), best};
    endfunction

    logic [DW+3:0] mu, mu4;
    assign mu       = max_unit(pack_out);
    assign mu4      = max_unit(pack_out4);
    assign max_idx  = force_en ? force_idx : mu[DW+3:DW];
    assign max_val  = mu[DW-1:0];
    assign max_idx4 = mu4[DW+3:DW];
    assign max_val4 = mu4[DW-1:0];

    // Reference: winner of the score list in arrival order.
    function automatic int ref_idx();
        int bi = 0;
        for (int k = 1; k < 10; k++) if (fs[k] > fs[bi]) bi = k;
        return bi;
    endfunction

    function automatic logic signed [DW-1:0] ref_val();
        return fs[ref_idx()];
    endfunction

    function automatic logic [10*DW-1:0] exp_pack();
        logic [10*DW-1:0] p = '0;
        for (int k = 0; k < 10; k++) p[DW*(9-k) +: DW] = fs[k];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_frame(input int lo, input int hi);
        for (int k = 0; k < 10; k++) fs[k] = DW'($urandom_range(hi - lo) + lo);
    endtask

    // Streams fs[0..9]; returns just after the edge of the 10th handshake.
    task automatic send_frame(input bit gaps);
        int n;
        for (int k = 0; k < 10; k++) begin
            if (gaps && $urandom_range(2) == 0) begin
                score_valid = 1'b0;
                repeat ($urandom_range(2, 1)) tick();
            end
            score_valid = 1'b1;
            score_in = fs[k];
            n = 0;
            #1;
            while (!score_ready && n < 20) begin tick(); n++; end
            if (n >= 20) begin
                total++; bad++;
                $display("FAIL send_timeout: digit %0d never accepted", k);
            end
            tick();
        end
        score_valid = 1'b0;
    endtask

    // Counts edges from the current point until result_valid (of either DUT).
    task automatic wait_result(input bit which, output int lat);
        lat = 0;
        while (!(which ? result_valid4 : result_valid) && lat < 50) begin
            tick();
            lat++;
        end
        if (lat >= 50) begin
            total++; bad++;
            $display("FAIL result_timeout: result_valid never rose");
        end
    endtask

    task automatic accept();
        result_ready = 1'b1;
        tick();
        result_ready = 1'b0;
        exp_fc++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        total++; if (score_ready !== 1'b1 || busy !== 1'b0) begin bad++;
            $display("FAIL reset_hs: ready=%0b busy=%0b want 1/0", score_ready, busy); end
        total++; if (result_valid !== 1'b0 || idx_err !== 1'b0) begin bad++;
            $display("FAIL reset_flags: rv=%0b err=%0b want 0/0", result_valid, idx_err); end
        total++; if (pack_out !== '0 || frame_count !== 16'd0) begin bad++;
            $display("FAIL reset_regs: pack=%h fc=%0d want 0", pack_out, frame_count); end
        total++; if (result_idx !== 4'd0 || result_val !== 16'sd0) begin bad++;
            $display("FAIL reset_result: idx=%0d val=%0d want 0/0", result_idx, result_val); end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        $display("reset: released");
    endtask

    task automatic test_basic();
        int lat;
        fs = '{16'sd5, -16'sd3, 16'sd100, 16'sd7, 16'sd0, -16'sd50, 16'sd99, 16'sd1, 16'sd2, 16'sd3};
        send_frame(1'b0);
        total++; if (pack_out[DW*7 +: DW] !== 16'd100 || pack_out !== exp_pack()) begin bad++;
            $display("FAIL basic_pack: lane7=%0d pack=%h want 100 / %h", pack_out[DW*7 +: DW], pack_out, exp_pack()); end
        total++; if (busy !== 1'b1 || result_valid !== 1'b0) begin bad++;
            $display("FAIL basic_settle: busy=%0b rv=%0b want 1/0", busy, result_valid); end
        wait_result(1'b0, lat);
        // One settle cycle: valid is visible after the next edge, i.e. in the
        // second cycle after the handshake cycle.
        total++; if (lat !== 1) begin bad++;
            $display("FAIL basic_latency: got %0d edges want 1", lat); end
        total++; if (result_idx !== 4'd2 || result_val !== 16'sd100) begin bad++;
            $display("FAIL basic_result: idx=%0d val=%0d want 2/100", result_idx, result_val); end
        accept();
        total++; if (frame_count !== 16'(exp_fc) || score_ready !== 1'b1 || result_valid !== 1'b0) begin bad++;
            $display("FAIL basic_accept: fc=%0d ready=%0b rv=%0b want %0d/1/0", frame_count, score_ready, result_valid, exp_fc); end
        $display("basic: idx=%0d val=%0d fc=%0d", result_idx, result_val, frame_count);
    endtask

    task automatic test_toggle_valid();
        int hs = 0;
        int k = 0;
        for (int k2 = 0; k2 < 10; k2++) fs[k2] = -16'sd32768;
        fs[9] = -16'sd1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            score_valid = (cyc % 2 == 0);
            score_in = (k < 10) ? fs[k] : 16'sh7fff;
            #1;
            if (score_valid && score_ready) begin hs++; k++; end
            tick();
        end
        score_valid = 1'b0;
        total++; if (hs !== 10) begin bad++;
            $display("FAIL toggle_handshakes: got %0d want 10", hs); end
        total++; if (result_valid !== 1'b1 || result_idx !== 4'd9 || result_val !== -16'sd1) begin bad++;
            $display("FAIL toggle_result: rv=%0b idx=%0d val=%0d want 1/9/-1", result_valid, result_idx, result_val); end
        total++; if (pack_out !== exp_pack()) begin bad++;
            $display("FAIL toggle_pack: got %h want %h", pack_out, exp_pack()); end
        accept();
        $display("toggle: handshakes=%0d idx=%0d val=%0d", hs, result_idx, result_val);
    endtask

    task automatic test_hold_stall();
        int lat;
        int errs = 0;
        logic signed [DW-1:0] first;
        rand_frame(-1000, 1000);
        send_frame(1'b0);
        wait_result(1'b0, lat);
        score_valid = 1'b1;
        for (int c = 0; c < 20; c++) begin
            score_in = DW'($urandom);
            #1;
            if (score_ready !== 1'b0 || result_valid !== 1'b1 || result_idx !== 4'(ref_idx()) ||
                result_val !== ref_val() || pack_out !== exp_pack()) errs++;
            tick();
        end
        total++; if (errs !== 0) begin bad++;
            $display("FAIL hold_stable: %0d bad cycles want 0", errs); end
        accept();
        first = DW'($urandom);
        score_in = first;
        tick();
        score_valid = 1'b0;
        total++; if (pack_out[DW*9 +: DW] !== first) begin bad++;
            $display("FAIL hold_restart: lane9=%0d want %0d", pack_out[DW*9 +: DW], first); end
        fs[0] = first;
        for (int k = 1; k < 10; k++) fs[k] = -16'sd20000;
        for (int k = 1; k < 10; k++) begin
            score_valid = 1'b1; score_in = fs[k]; tick();
        end
        score_valid = 1'b0;
        wait_result(1'b0, lat);
        total++; if (result_idx !== 4'(ref_idx()) || result_val !== ref_val()) begin bad++;
            $display("FAIL hold_next: idx=%0d val=%0d want %0d/%0d", result_idx, result_val, ref_idx(), ref_val()); end
        accept();
        $display("hold: stall cycles=20 bad=%0d next idx=%0d", errs, result_idx);
    endtask

    task automatic test_frame_clr();
        int lat;
        rand_frame(-400, 400);
        for (int k = 0; k < 6; k++) begin
            score_valid = 1'b1; score_in = fs[k]; tick();
        end
        frame_clr = 1'b1;
        score_in = 16'sd30000;
        #1;
        total++; if (score_ready !== 1'b0) begin bad++;
            $display("FAIL clr_ready: got %0b want 0", score_ready); end
        tick();
        frame_clr = 1'b0;
        score_valid = 1'b0;
        rand_frame(-400, 400);
        fs[4] = 16'sd500;
        send_frame(1'b0);
        wait_result(1'b0, lat);
        total++; if (result_idx !== 4'd4 || result_val !== 16'sd500) begin bad++;
            $display("FAIL clr_result: idx=%0d val=%0d want 4/500", result_idx, result_val); end
        accept();
        total++; if (frame_count !== 16'(exp_fc)) begin bad++;
            $display("FAIL clr_count: got %0d want %0d", frame_count, exp_fc); end
        $display("frame_clr: idx=%0d fc=%0d", result_idx, frame_count);
    endtask

    task automatic test_idx_err();
        int lat;
        rand_frame(-3000, 3000);
        force_en = 1'b1;
        force_idx = 4'd12;
        send_frame(1'b1);
        wait_result(1'b0, lat);
        force_en = 1'b0;
        total++; if (idx_err !== 1'b1 || result_idx !== 4'd12 || result_val !== ref_val()) begin bad++;
            $display("FAIL idxerr_set: err=%0b idx=%0d val=%0d want 1/12/%0d", idx_err, result_idx, result_val, ref_val()); end
        accept();
        rand_frame(-3000, 3000);
        send_frame(1'b0);
        wait_result(1'b0, lat);
        total++; if (idx_err !== 1'b0 || result_idx !== 4'(ref_idx())) begin bad++;
            $display("FAIL idxerr_clear: err=%0b idx=%0d want 0/%0d", idx_err, result_idx, ref_idx()); end
        accept();
        $display("idx_err: cleared to %0b", idx_err);
    endtask

    task automatic test_random();
        int lat;
        for (int f = 0; f < 8; f++) begin
            rand_frame(-32768, 32767);
            send_frame(1'b1);
            wait_result(1'b0, lat);
            total++; if (lat !== 1 || result_idx !== 4'(ref_idx()) || result_val !== ref_val()) begin bad++;
                $display("FAIL random_result: frame %0d lat=%0d idx=%0d val=%0d want 1/%0d/%0d",
                         f, lat, result_idx, result_val, ref_idx(), ref_val()); end
            repeat ($urandom_range(3)) tick();
            accept();
            total++; if (frame_count !== 16'(exp_fc)) begin bad++;
                $display("FAIL random_count: got %0d want %0d", frame_count, exp_fc); end
            $display("random frame %0d: idx=%0d val=%0d fc=%0d", f, result_idx, result_val, frame_count);
        end
    endtask

    task automatic test_async_reset();
        int lat;
        rand_frame(-500, 500);
        send_frame(1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (busy !== 1'b0 || result_valid !== 1'b0 || pack_out !== '0 || frame_count !== 16'd0) begin bad++;
            $display("FAIL async_reset: busy=%0b rv=%0b pack=%h fc=%0d want 0", busy, result_valid, pack_out, frame_count); end
        @(negedge clk);
        rst_n = 1'b1;
        rst_n4 = 1'b1;
        exp_fc = 0;
        tick();
        total++; if (result_valid !== 1'b0 || score_ready !== 1'b1) begin bad++;
            $display("FAIL async_after: rv=%0b ready=%0b want 0/1", result_valid, score_ready); end
        rand_frame(-500, 500);
        send_frame(1'b1);
        wait_result(1'b1, lat);
        total++; if (lat !== 4 || result_idx4 !== 4'(ref_idx()) || result_val4 !== ref_val()) begin bad++;
            $display("FAIL settle4: lat=%0d idx=%0d val=%0d want 4/%0d/%0d", lat, result_idx4, result_val4, ref_idx(), ref_val()); end
        total++; if (result_idx !== 4'(ref_idx())) begin bad++;
            $display("FAIL async_restart: idx=%0d want %0d", result_idx, ref_idx()); end
        accept();
        $display("async reset + settle4: lat=%0d idx=%0d", lat, result_idx4);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle_valid();
        test_hold_stall();
        test_frame_clr();
        test_idx_err();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
